mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low; sampled on rising edge of clock.
REQ-003 SHALL have port: mem_ready  in  1  shared memory completes the pending access this cycle.
REQ-004 SHALL have port: except  in  1  decoder flags an unrecognised opcode/funct.
REQ-005 SHALL have port: mem_read  in  1  decoder: instruction is a load (lw/lbu).
REQ-006 SHALL have port: word_we  in  1  decoder: word store.
REQ-007 SHALL have port: byte_we  in  1  decoder: byte store.
REQ-008 SHALL have port: writeenable  in  1  decoder: instruction writes the register file.
REQ-009 SHALL have port: mem_req  out  1  request to shared single-port memory.
REQ-010 SHALL have port: mem_addr_sel  out  1  memory address source; 0 = PC, 1 = ALU result.
REQ-011 SHALL have port: mem_wr  out  1  current request is a store.
REQ-012 SHALL have port: ir_we  out  1  capture fetched word into instruction register.
REQ-013 SHALL have port: pc_we  out  1  commit next PC.
REQ-014 SHALL have port: rf_we  out  1  register-file write strobe.
REQ-015 SHALL have port: halted  out  1  sticky halt indicator.
REQ-016 SHALL have port: bus_err  out  1  sticky; halt caused by memory timeout.
REQ-017 SHALL have port: retired  out  32  count of completed instructions.

Function
REQ-018 SHALL implement states FETCH, DECODE, MEM, WB, HALT; all outputs are Moore/registered-state decoded except strobes qualified by mem_ready.
REQ-019 FETCH: mem_req=1, mem_addr_sel=0, mem_wr=0; on mem_ready, ir_we=1 same cycle and next state DECODE.
REQ-020 DECODE (1 cycle): except -> HALT; else mem_read|word_we|byte_we -> MEM; else -> WB.
REQ-021 MEM: mem_req=1, mem_addr_sel=1, mem_wr=word_we|byte_we; on mem_ready: load -> WB; store -> pc_we=1, retired+1, -> FETCH.
REQ-022 WB (1 cycle): rf_we=writeenable, pc_we=1, retired+1, -> FETCH.
REQ-023 HALT: all strobes and mem_req 0, halted=1; remains until reset.
REQ-024 Decoder inputs SHALL be used only in DECODE, MEM, WB (IR stable after ir_we).
REQ-025 Zero-wait latency: ALU/branch/jump 3 cycles, load 4, store 3; each wait cycle adds 1.
REQ-026 Wait timer: counts consecutive cycles in FETCH/MEM with mem_ready=0; clears on mem_ready or state change; reaching 16 -> HALT with bus_err=1.
REQ-027 mem_ready on the same cycle the timer would expire SHALL win (access completes, no bus_err).
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 retired SHALL wrap 0xFFFFFFFF -> 0 without flag.
REQ-030 except and mem_read both high in DECODE SHALL take HALT (except has priority).

Reset
REQ-031 reset=0 at a clock edge SHALL force state FETCH, timer 0, retired 0, halted 0, bus_err 0, from any state including mid-access.
REQ-032 During reset cycle outputs SHALL be: mem_req 0, ir_we 0, pc_we 0, rf_we 0, mem_wr 0, mem_addr_sel 0.
REQ-033 First mem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-034 State encoding and TIMEOUT_CYCLES=16 SHALL live in shared package mips_ctrl_pkg.
REQ-035 Wait timer SHALL be sub-module mips_wait_timer (inputs clear, count; output expired).

Verification
REQ-036 Zero-wait add (writeenable=1), mem_ready held 1 -> ir_we cycle 1, rf_we+pc_we cycle 3, retired=1.
REQ-037 lw with mem_ready delayed 2 cycles in MEM -> mem_addr_sel=1 for 3 cycles, rf_we at cycle 6, retired=1.
REQ-038 sb -> mem_wr=1 in MEM, rf_we never 1, pc_we with mem_ready, back to FETCH.
REQ-039 except=1 in DECODE -> HALT, halted=1, no further mem_req for 20 cycles; reset=0 then 1 -> FETCH, halted=0.
REQ-040 mem_ready low 16 cycles in FETCH -> HALT, bus_err=1; variant with mem_ready on cycle 16 -> DECODE, bus_err=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state encoding, timeout constant and decode helpers for the multicycle MIPS controller
package mips_ctrl_pkg;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int TIMER_W        = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic is_store(input logic word_we, input logic byte_we);
    return word_we | byte_we;
  endfunction

  function automatic logic needs_mem(input logic mem_read, input logic word_we,
                                     input logic byte_we);
    return mem_read | is_store(word_we, byte_we);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// rtl/mips_mc_ctrl_if.sv - decoder, memory handshake and status signals of the multicycle controller
interface mips_mc_ctrl_if;

  logic        mem_ready;
  logic        except;
  logic        mem_read;
  logic        word_we;
  logic        byte_we;
  logic        writeenable;

  logic        mem_req;
  logic        mem_addr_sel;
  logic        mem_wr;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        halted;
  logic        bus_err;
  logic [31:0] retired;

  modport master (
    input  mem_ready, except, mem_read, word_we, byte_we, writeenable,
    output mem_req, mem_addr_sel, mem_wr, ir_we, pc_we, rf_we, halted, bus_err, retired
  );

  modport slave (
    output mem_ready, except, mem_read, word_we, byte_we, writeenable,
    input  mem_req, mem_addr_sel, mem_wr, ir_we, pc_we, rf_we, halted, bus_err, retired
  );

endinterface

// File: rtl/mips_wait_timer.sv
// rtl/mips_wait_timer.sv - counts consecutive stalled memory cycles; expired flags the last allowed one
module mips_wait_timer
  import mips_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // expired is raised during the TIMEOUT_CYCLES-th consecutive stalled cycle
  assign expired = count && !clear && (cnt_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM sharing one single-port memory for fetch and data
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  mips_mc_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        bus_err_q, bus_err_d;

  logic        in_access;
  logic        waiting;
  logic        expired;
  logic        store;

  logic        mem_req;
  logic        mem_addr_sel;
  logic        mem_wr;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;

  assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign waiting   = in_access && !bus.mem_ready;
  assign store     = is_store(bus.word_we, bus.byte_we);

  mips_wait_timer u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!waiting),
    .count   (waiting),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
    end
  end

  // a completing access always beats the timeout on the same cycle
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (bus.except) begin
          state_d = ST_HALT;
        end else if (needs_mem(bus.mem_read, bus.word_we, bus.byte_we)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = store ? ST_FETCH : ST_WB;
        end else if (expired) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_wr       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = bus.mem_ready;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_wr       = store;
        pc_we        = bus.mem_ready && store;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = bus.writeenable;
      end
      default: begin
      end
    endcase
    // nothing may touch memory or architectural state while reset is held
    if (!reset) begin
      mem_req      = 1'b0;
      mem_addr_sel = 1'b0;
      mem_wr       = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      rf_we        = 1'b0;
    end
  end

  assign retired_d = pc_we ? retired_q + 32'd1 : retired_q;

  assign bus.mem_req      = mem_req;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.mem_wr       = mem_wr;
  assign bus.ir_we        = ir_we;
  assign bus.pc_we        = pc_we;
  assign bus.rf_we        = rf_we;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.bus_err      = bus_err_q;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed table, corner sequences and randomized instruction stream for mips_mc_ctrl
module tb_mips_mc_ctrl;

  localparam logic [7:0] O_REQ  = 8'b1000_0000;
  localparam logic [7:0] O_ASEL = 8'b0100_0000;
  localparam logic [7:0] O_WR   = 8'b0010_0000;
  localparam logic [7:0] O_IR   = 8'b0001_0000;
  localparam logic [7:0] O_PC   = 8'b0000_1000;
  localparam logic [7:0] O_RF   = 8'b0000_0100;
  localparam logic [7:0] O_HLT  = 8'b0000_0010;
  localparam logic [7:0] O_BERR = 8'b0000_0001;

  localparam logic [5:0] I_RDY = 6'b100000;
  localparam logic [5:0] I_EXC = 6'b010000;
  localparam logic [5:0] I_RD  = 6'b001000;
  localparam logic [5:0] I_WW  = 6'b000100;
  localparam logic [5:0] I_BW  = 6'b000010;
  localparam logic [5:0] I_WE  = 6'b000001;

  typedef struct {
    logic        rst_n;
    logic [5:0]  in;
    logic [7:0]  exp;
    logic [31:0] ret;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic r, input logic [5:0] i, input logic [7:0] e,
                              input logic [31:0] rt);
    vec_t v;
    v.rst_n = r;
    v.in    = i;
    v.exp   = e;
    v.ret   = rt;
    return v;
  endfunction

  // called at a falling edge: drive, settle, compare, then move to the next falling edge
  task automatic cyc(input logic rst_n, input logic [5:0] in, input logic [7:0] exp,
                     input logic [31:0] exp_ret, input string tag);
    logic [7:0] got;
    reset = rst_n;
    {bus.mem_ready, bus.except, bus.mem_read, bus.word_we, bus.byte_we, bus.writeenable} = in;
    #1;
    got = {bus.mem_req, bus.mem_addr_sel, bus.mem_wr, bus.ir_we,
           bus.pc_we, bus.rf_we, bus.halted, bus.bus_err};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {req,asel,wr,ir,pc,rf,halt,berr} got %b expected %b", tag, got, exp);
    end
    n_checks++;
    if (bus.retired !== exp_ret) begin
      n_fail++;
      $display("FAIL %s: retired got %0d expected %0d", tag, bus.retired, exp_ret);
    end
    @(negedge clock);
  endtask

  function automatic logic [5:0] junk();
    logic [5:0] j;
    j = 6'($urandom);
    return j & ~I_RDY;
  endfunction

  function automatic logic [5:0] any_rdy();
    return ($urandom_range(0, 1) != 0) ? I_RDY : 6'd0;
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 3));
    if (r < 17) return 15;
    if (r == 17) return 14;
    return 16 + int'($urandom_range(0, 2));
  endfunction

  // instruction-level reference: latency rules produce the expected per-cycle trace
  task automatic run_random(input int n_instr);
    logic [31:0] ret_m;
    logic [5:0]  dec;
    logic        st;
    logic        ld;
    logic        exc;
    logic        we;
    int          kind;
    int          fw;
    int          mw;
    ret_m = 0;
    for (int n = 0; n < n_instr; n++) begin
      kind = int'($urandom_range(0, 7));
      fw   = pick_wait();
      mw   = pick_wait();
      exc  = (kind == 0);
      ld   = (kind == 3) || (kind == 4);
      st   = (kind == 5) || (kind == 6);
      we   = ld ? 1'b1 : (st ? 1'b0 : 1'(($urandom_range(0, 1))));
      dec  = {1'b0, exc, ld || (exc && $urandom_range(0, 1) != 0),
              kind == 5, kind == 6, we};
      for (int i = 0; i < fw && i < 16; i++) cyc(1'b1, junk(), O_REQ, ret_m, "rnd_fetch_wait");
      if (fw >= 16) begin
        cyc(1'b1, junk() | any_rdy(), O_HLT | O_BERR, ret_m, "rnd_fetch_timeout");
        cyc(1'b0, junk(), O_HLT | O_BERR, ret_m, "rnd_reset_after_timeout");
        ret_m = 0;
        continue;
      end
      cyc(1'b1, junk() | I_RDY, O_REQ | O_IR, ret_m, "rnd_fetch_done");
      cyc(1'b1, dec | any_rdy(), 8'd0, ret_m, "rnd_decode");
      if (exc) begin
        cyc(1'b1, junk() | any_rdy(), O_HLT, ret_m, "rnd_except_halt");
        cyc(1'b0, junk(), O_HLT, ret_m, "rnd_reset_after_except");
        ret_m = 0;
        continue;
      end
      if (ld || st) begin
        for (int i = 0; i < mw && i < 16; i++)
          cyc(1'b1, dec, O_REQ | O_ASEL | (st ? O_WR : 8'd0), ret_m, "rnd_mem_wait");
        if (mw >= 16) begin
          cyc(1'b1, dec | any_rdy(), O_HLT | O_BERR, ret_m, "rnd_mem_timeout");
          cyc(1'b0, junk(), O_HLT | O_BERR, ret_m, "rnd_reset_after_mem_timeout");
          ret_m = 0;
          continue;
        end
        cyc(1'b1, dec | I_RDY, O_REQ | O_ASEL | (st ? (O_WR | O_PC) : 8'd0), ret_m,
            "rnd_mem_done");
        if (st) begin
          ret_m = ret_m + 1;
          continue;
        end
      end
      cyc(1'b1, dec | any_rdy(), O_PC | (we ? O_RF : 8'd0), ret_m, "rnd_writeback");
      ret_m = ret_m + 1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    {bus.mem_ready, bus.except, bus.mem_read, bus.word_we, bus.byte_we, bus.writeenable} = 6'd0;
    repeat (2) @(negedge clock);

    // add, lw with two MEM waits, sb, branch, zero-wait sw, reset during a fetch
    tbl.push_back(mk(1'b0, I_RDY | I_WE,         8'd0,                         0));
    tbl.push_back(mk(1'b1, I_RDY | I_WE,         O_REQ | O_IR,                 0));
    tbl.push_back(mk(1'b1, I_RDY | I_WE,         8'd0,                         0));
    tbl.push_back(mk(1'b1, I_RDY | I_WE,         O_PC | O_RF,                  0));
    tbl.push_back(mk(1'b1, I_RDY | I_RD | I_WE,  O_REQ | O_IR,                 1));
    tbl.push_back(mk(1'b1, I_RD | I_WE,          8'd0,                         1));
    tbl.push_back(mk(1'b1, I_RD | I_WE,          O_REQ | O_ASEL,               1));
    tbl.push_back(mk(1'b1, I_RD | I_WE,          O_REQ | O_ASEL,               1));
    tbl.push_back(mk(1'b1, I_RDY | I_RD | I_WE,  O_REQ | O_ASEL,               1));
    tbl.push_back(mk(1'b1, I_RD | I_WE,          O_PC | O_RF,                  1));
    tbl.push_back(mk(1'b1, I_RDY | I_BW,         O_REQ | O_IR,                 2));
    tbl.push_back(mk(1'b1, I_RDY | I_BW,         8'd0,                         2));
    tbl.push_back(mk(1'b1, I_BW,                 O_REQ | O_ASEL | O_WR,        2));
    tbl.push_back(mk(1'b1, I_RDY | I_BW,         O_REQ | O_ASEL | O_WR | O_PC, 2));
    tbl.push_back(mk(1'b1, 6'd0,                 O_REQ,                        3));
    tbl.push_back(mk(1'b1, I_RDY,                O_REQ | O_IR,                 3));
    tbl.push_back(mk(1'b1, 6'd0,                 8'd0,                         3));
    tbl.push_back(mk(1'b1, I_RDY,                O_PC,                         3));
    tbl.push_back(mk(1'b1, I_RDY | I_WW,         O_REQ | O_IR,                 4));
    tbl.push_back(mk(1'b1, I_WW,                 8'd0,                         4));
    tbl.push_back(mk(1'b1, I_RDY | I_WW,         O_REQ | O_ASEL | O_WR | O_PC, 4));
    tbl.push_back(mk(1'b1, 6'd0,                 O_REQ,                        5));
    tbl.push_back(mk(1'b0, I_RDY,                8'd0,                         5));
    tbl.push_back(mk(1'b1, 6'd0,                 O_REQ,                        0));
    tbl.push_back(mk(1'b1, I_RDY,                O_REQ | O_IR,                 0));
    foreach (tbl[k]) cyc(tbl[k].rst_n, tbl[k].in, tbl[k].exp, tbl[k].ret, $sformatf("table_%0d", k));

    // except with mem_read in DECODE halts; halt holds for 20 cycles until reset
    cyc(1'b1, I_EXC | I_RD | I_RDY, 8'd0, 0, "except_decode");
    for (int i = 0; i < 20; i++) cyc(1'b1, junk() | any_rdy(), O_HLT, 0, $sformatf("halt_hold_%0d", i));
    cyc(1'b0, I_RDY, O_HLT, 0, "halt_reset_cycle");
    cyc(1'b1, I_RDY | I_WE, O_REQ | O_IR, 0, "post_halt_fetch");
    cyc(1'b1, I_WE, 8'd0, 0, "post_halt_decode");
    cyc(1'b1, I_WE, O_PC | O_RF, 0, "post_halt_wb");

    // sixteen stalled fetch cycles time out
    for (int i = 0; i < 16; i++) cyc(1'b1, 6'd0, O_REQ, 1, $sformatf("fetch_stall_%0d", i));
    cyc(1'b1, I_RDY, O_HLT | O_BERR, 1, "fetch_timeout_halt");
    cyc(1'b0, 6'd0, O_HLT | O_BERR, 1, "fetch_timeout_reset");

    // ready on the sixteenth cycle wins over the timeout
    for (int i = 0; i < 15; i++) cyc(1'b1, 6'd0, O_REQ, 0, $sformatf("fetch_late_%0d", i));
    cyc(1'b1, I_RDY, O_REQ | O_IR, 0, "fetch_ready_at_16");
    cyc(1'b1, 6'd0, 8'd0, 0, "late_decode_no_berr");
    cyc(1'b1, 6'd0, O_PC, 0, "late_wb");

    // load whose data access stalls into a timeout
    cyc(1'b1, I_RDY | I_RD, O_REQ | O_IR, 1, "mem_to_fetch");
    cyc(1'b1, I_RD, 8'd0, 1, "mem_to_decode");
    for (int i = 0; i < 16; i++) cyc(1'b1, I_RD, O_REQ | O_ASEL, 1, $sformatf("mem_stall_%0d", i));
    cyc(1'b1, I_RD, O_HLT | O_BERR, 1, "mem_timeout_halt");
    cyc(1'b0, 6'd0, O_HLT | O_BERR, 1, "mem_timeout_reset");

    run_random(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
